// File: rtl/scan_sel_3to8.sv
// Channel sequencer feeding a 3-to-8 decoder: walks the set bits of a latched
// mask lowest-to-highest, holding each channel for a programmable dwell.
module scan_sel_3to8 #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [DWELL_W-1:0] DW_ONE = DWELL_W'(1);

    // Current state is kept as a named signal so checkers can bind to it.
    state_t             state, state_nx;
    logic [2:0]         sel_nx;
    logic               en_nx, busy_nx, done_nx;
    logic [DWELL_W-1:0] cnt, cnt_nx;
    logic [7:0]         mask_q, mask_nx;
    logic               cont_q, cont_nx;
    logic [DWELL_W-1:0] dwell_q, dwell_nx;

    logic [DWELL_W-1:0] start_dwell_eff;
    logic [2:0]         start_low;
    logic [2:0]         latched_low;
    logic [2:0]         next_ch;
    logic               has_next;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    // A dwell of 0 behaves as 1; dwell_q always holds the effective value.
    assign start_dwell_eff = (dwell == '0) ? DW_ONE : dwell;
    assign start_low       = lowest_bit(mask);
    assign latched_low     = lowest_bit(mask_q);

    always_comb begin
        has_next = 1'b0;
        next_ch  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (3'(i) > sel)) begin
                has_next = 1'b1;
                next_ch  = 3'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        en_nx    = en;
        busy_nx  = busy;
        done_nx  = 1'b0;
        cnt_nx   = cnt;
        mask_nx  = mask_q;
        cont_nx  = cont_q;
        dwell_nx = dwell_q;

        case (state)
            IDLE: begin
                sel_nx  = 3'd0;
                en_nx   = 1'b0;
                busy_nx = 1'b0;
                if (start) begin
                    if (mask != 8'd0) begin
                        state_nx = SCAN;
                        mask_nx  = mask;
                        cont_nx  = cont;
                        dwell_nx = start_dwell_eff;
                        sel_nx   = start_low;
                        en_nx    = 1'b1;
                        busy_nx  = 1'b1;
                        cnt_nx   = start_dwell_eff - DW_ONE;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (stop) begin
                    state_nx = IDLE;
                    sel_nx   = 3'd0;
                    en_nx    = 1'b0;
                    busy_nx  = 1'b0;
                    cnt_nx   = '0;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - DW_ONE;
                end else if (has_next) begin
                    sel_nx = next_ch;
                    cnt_nx = dwell_q - DW_ONE;
                end else if (cont_q) begin
                    sel_nx = latched_low;
                    cnt_nx = dwell_q - DW_ONE;
                end else begin
                    state_nx = IDLE;
                    sel_nx   = 3'd0;
                    en_nx    = 1'b0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                sel_nx   = 3'd0;
                en_nx    = 1'b0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= 3'd0;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            mask_q  <= 8'd0;
            cont_q  <= 1'b0;
            dwell_q <= '0;
        end else begin
            state   <= state_nx;
            sel     <= sel_nx;
            en      <= en_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            cnt     <= cnt_nx;
            mask_q  <= mask_nx;
            cont_q  <= cont_nx;
            dwell_q <= dwell_nx;
        end
    end

endmodule

// File: tb/tb_scan_sel_3to8.sv
// Bench for scan_sel_3to8: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against a queue-based channel model.
module tb_scan_sel_3to8;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst, start, stop, cont;
    logic [7:0]    mask;
    logic [DW-1:0] dwell;
    logic [2:0]    sel;
    logic          en, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_sel_3to8 #(.DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
        .mask(mask), .dwell(dwell), .sel(sel), .en(en), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pend_q lists every channel presentation still to come in the
    // current pass, one entry per cycle.
    logic [2:0] m_sel;
    logic       m_en, m_busy, m_done, m_cont;
    logic [7:0] m_mask;
    int         m_dwell;
    logic [2:0] pend_q[$];

    task automatic build_pass();
        for (int c = 0; c < 8; c++)
            if (m_mask[c])
                for (int k = 0; k < m_dwell; k++) pend_q.push_back(3'(c));
    endtask

    task automatic model_idle();
        m_sel  = 3'd0;
        m_en   = 1'b0;
        m_busy = 1'b0;
        pend_q.delete();
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            model_idle();
            m_mask = 8'd0; m_cont = 1'b0; m_dwell = 0;
        end else if (!m_busy) begin
            if (start && mask == 8'd0) m_done = 1'b1;
            else if (start) begin
                m_mask  = mask;
                m_cont  = cont;
                m_dwell = (dwell == '0) ? 1 : int'(dwell);
                build_pass();
                m_sel  = pend_q.pop_front();
                m_en   = 1'b1;
                m_busy = 1'b1;
            end
        end else if (stop) begin
            model_idle();
        end else if (pend_q.size() != 0) begin
            m_sel = pend_q.pop_front();
        end else if (m_cont) begin
            build_pass();
            m_sel = pend_q.pop_front();
        end else begin
            model_idle();
            m_done = 1'b1;
        end
    end

    // Compare and observation, #1 after each active edge.
    logic [2:0] obs_q[$];
    int busy_cnt, done_cnt;

    always @(posedge clk) begin
        #1;
        chk("sel", 8'(sel), 8'(m_sel));
        chk("en", 8'(en), 8'(m_en));
        chk("busy", 8'(busy), 8'(m_busy));
        chk("done", 8'(done), 8'(m_done));
        if (en === 1'b1) obs_q.push_back(sel);
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic clear_obs();
        obs_q.delete();
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [7:0] m, input logic [DW-1:0] d, input logic c);
        @(negedge clk);
        mask = m; dwell = d; cont = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("idle_timeout", 8'd1, 8'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_seq(input string name, input logic [2:0] exp[$]);
        chk({name, "_len"}, 8'(obs_q.size()), 8'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs_q.size(); i++)
            chk(name, 8'(obs_q[i]), 8'(exp[i]));
    endtask

    initial begin
        logic [2:0] exp[$];
        int n;
        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; mask = 8'd0; dwell = '0;
        busy_cnt = 0; done_cnt = 0;
        repeat (2) @(negedge clk);
        chk("reset_sel", 8'(sel), 8'd0);
        chk("reset_en", 8'(en), 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full scan, dwell 1.
        clear_obs();
        do_start(8'hFF, 4'd1, 1'b0);
        wait_idle();
        exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        chk_seq("full_seq", exp);
        chk("full_done", 8'(done_cnt), 8'd1);

        // Sparse scan with dwell 3.
        clear_obs();
        do_start(8'b1010_0100, 4'd3, 1'b0);
        wait_idle();
        exp = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd7, 3'd7, 3'd7};
        chk_seq("sparse_seq", exp);
        chk("sparse_busy", 8'(busy_cnt), 8'd9);
        chk("sparse_done", 8'(done_cnt), 8'd1);

        // Continuous 0,0,7,7 then stop sampled on the wrap edge.
        clear_obs();
        do_start(8'h81, 4'd2, 1'b1);
        repeat (3) @(negedge clk);
        exp = '{3'd0, 3'd0, 3'd7, 3'd7};
        chk_seq("cont_seq", exp);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_en", 8'(en), 8'd0);
        chk("stop_sel", 8'(sel), 8'd0);
        repeat (3) @(negedge clk);
        chk("stop_done", 8'(done_cnt), 8'd0);

        // Empty mask: single done pulse, no enable.
        clear_obs();
        do_start(8'h00, 4'd3, 1'b0);
        repeat (3) @(negedge clk);
        chk("empty_done", 8'(done_cnt), 8'd1);
        chk("empty_en", 8'(obs_q.size()), 8'd0);

        // Dwell 0 treated as 1.
        clear_obs();
        do_start(8'h03, 4'd0, 1'b0);
        wait_idle();
        exp = '{3'd0, 3'd1};
        chk_seq("dwell0_seq", exp);

        // Inputs changing while busy are ignored.
        clear_obs();
        do_start(8'h10, 4'd4, 1'b0);
        do_start(8'hFF, 4'd1, 1'b1);
        wait_idle();
        exp = '{3'd4, 3'd4, 3'd4, 3'd4};
        chk_seq("busy_ignore_seq", exp);
        chk("busy_ignore_done", 8'(done_cnt), 8'd1);

        // Reset mid-scan while channel 5 is presented.
        clear_obs();
        do_start(8'hFF, 4'd2, 1'b0);
        n = 0;
        while (sel !== 3'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_sel5", 8'(sel), 8'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_sel", 8'(sel), 8'd0);
        chk("rst_mid_en", 8'(en), 8'd0);
        chk("rst_mid_busy", 8'(busy), 8'd0);
        chk("rst_mid_done", 8'(done_cnt), 8'd0);
        clear_obs();
        do_start(8'h21, 4'd1, 1'b0);
        wait_idle();
        exp = '{3'd0, 3'd5};
        chk_seq("after_rst_seq", exp);

        // Random traffic, model-checked each cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            cont  = $urandom_range(0, 1);
            mask  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            dwell = DW'($urandom_range(0, 15));
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
